handshake_fifo: RTL



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_regfile.sv | 40 ++++
 rtl/handshake_fifo.sv | 77 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the handshake FIFO: default geometry, a default
// pointer type, and the clock period the mapped netlist has to meet.
package fifo_pkg;

  // Default geometry of the elastic buffer.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Pointers carry one extra wrap bit above the entry address.
  localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH) + 1;
  typedef logic [DEFAULT_PTR_W-1:0] ptr_t;

  // Clock period (time units) the gate-level netlist is timed against.
  localparam int NETLIST_CLK_PERIOD = 40;

  // Pointer width for an arbitrary power-of-two depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage for the handshake FIFO: DEPTH entries of WIDTH bits, one write
// port and one combinational read port. Entries are never reset, so they
// map to plain flops; the read side is a mux so the head word falls through.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEFAULT_DEPTH)
) (
  input  logic             C,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] entries [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] ENTRY_ADDR = AW'(gi);
      logic [WIDTH-1:0] entry_reg;

      // Capture write data when this entry is the write target.
      always_ff @(posedge C) begin
        if (we && (waddr == ENTRY_ADDR)) begin
          entry_reg <= wdata;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // DEPTH is a power of two, so every raddr value selects a real entry.
  assign rdata = entries[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Synchronous FIFO with valid/ready on both sides. Pointers have an extra
// wrap bit so full and empty are distinguished without a separate counter;
// every output is a decode of registered state only, never of in_valid or
// out_ready, so the block never closes a combinational loop with its peers.
module handshake_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wp_reg;
  logic [AW:0] rp_reg;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Equal pointers mean empty; same address with opposite wrap bits means full.
  assign empty = (wp_reg == rp_reg);
  assign full  = (wp_reg[AW] != rp_reg[AW]) &&
                 (wp_reg[AW-1:0] == rp_reg[AW-1:0]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = wp_reg - rp_reg;

  // A transfer needs both sides; a full FIFO ignores in_valid and an empty
  // one ignores out_ready, which gives the push-only / pop-only behaviour.
  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  // Write pointer: advances once per accepted word, wraps naturally.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      wp_reg <= '0;
    end else if (push) begin
      wp_reg <= wp_reg + PTR_ONE;
    end
  end

  // Read pointer: advances once per consumed word, wraps naturally.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      rp_reg <= '0;
    end else if (pop) begin
      rp_reg <= rp_reg + PTR_ONE;
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .C     (C),
    .we    (push),
    .waddr (wp_reg[AW-1:0]),
    .wdata (in_data),
    .raddr (rp_reg[AW-1:0]),
    .rdata (out_data)
  );

endmodule
